// File: rtl/csr_file_pkg.sv
// Shared CSR address map, field positions and fixed field values for the
// machine-mode/debug CSR file and its counter sub-block.
package csr_file_pkg;

  localparam logic [11:0] CSR_MSTATUS   = 12'h300;
  localparam logic [11:0] CSR_MISA      = 12'h301;
  localparam logic [11:0] CSR_MIE       = 12'h304;
  localparam logic [11:0] CSR_MTVEC     = 12'h305;
  localparam logic [11:0] CSR_MSCRATCH  = 12'h340;
  localparam logic [11:0] CSR_MEPC      = 12'h341;
  localparam logic [11:0] CSR_MCAUSE    = 12'h342;
  localparam logic [11:0] CSR_MIP       = 12'h344;
  localparam logic [11:0] CSR_MCYCLE    = 12'hB00;
  localparam logic [11:0] CSR_MCYCLEH   = 12'hB80;
  localparam logic [11:0] CSR_MINSTRET  = 12'hB02;
  localparam logic [11:0] CSR_MINSTRETH = 12'hB82;
  localparam logic [11:0] CSR_CYCLE     = 12'hC00;
  localparam logic [11:0] CSR_CYCLEH    = 12'hC80;
  localparam logic [11:0] CSR_INSTRET   = 12'hC02;
  localparam logic [11:0] CSR_INSTRETH  = 12'hC82;
  localparam logic [11:0] CSR_MHARTID   = 12'hF14;
  localparam logic [11:0] CSR_DCSR      = 12'h7B0;
  localparam logic [11:0] CSR_DPC       = 12'h7B1;
  localparam logic [11:0] CSR_DSCRATCH0 = 12'h7B2;
  localparam logic [11:0] CSR_DSCRATCH1 = 12'h7B3;

  localparam int MSTATUS_MIE  = 3;
  localparam int MSTATUS_MPIE = 7;
  localparam logic [1:0] MSTATUS_MPP = 2'b11;

  localparam int MIE_MSIE = 3;
  localparam int MIE_MTIE = 7;
  localparam int MIE_MEIE = 11;
  localparam logic [31:0] MIE_MASK = (32'd1 << MIE_MSIE) | (32'd1 << MIE_MTIE) | (32'd1 << MIE_MEIE);

  localparam logic [31:0] MISA_VAL       = 32'h40000100;
  localparam logic [3:0]  DCSR_XDEBUGVER = 4'd4;
  localparam logic [1:0]  DCSR_PRV       = 2'b11;
  localparam int          DCSR_EBREAKM   = 15;

endpackage

// File: rtl/csr_file_counter64.sv
// 64-bit free-running counter with independently writable halves; a write to
// either half replaces it and skips that cycle's increment without carry.
module csr_counter64 (
  input  logic        clk,
  input  logic        rst,
  input  logic        inc,
  input  logic        we_lo,
  input  logic        we_hi,
  input  logic [63:0] wdata,
  output logic [63:0] value
);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      value <= '0;
    end else if (we_lo || we_hi) begin
      if (we_lo) value[31:0]  <= wdata[31:0];
      if (we_hi) value[63:32] <= wdata[63:32];
    end else if (inc) begin
      value <= value + 64'd1;
    end
  end

endmodule

// File: rtl/csr_file.sv
// Machine-mode and debug CSR storage: two write ports (execute, exception),
// trap-entry/mret stacking of mstatus, and the mcycle/minstret counters.
module csr_file
  import csr_file_pkg::*;
#(
  parameter logic [31:0] HART_ID   = 32'h0,
  parameter logic [31:0] MTVEC_RST = 32'h0
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        ex_we_i,
  input  logic [11:0] ex_waddr_i,
  input  logic [31:0] ex_wdata_i,
  input  logic [11:0] raddr_i,
  output logic [31:0] rdata_o,
  input  logic        excp_we_i,
  input  logic [31:0] excp_waddr_i,
  input  logic [31:0] excp_wdata_i,
  input  logic        inst_mret_i,
  input  logic        inst_retire_i,
  input  logic        irq_software_i,
  input  logic        irq_timer_i,
  input  logic        irq_external_i,
  output logic [31:0] mtvec_o,
  output logic [31:0] mepc_o,
  output logic [31:0] mstatus_o,
  output logic [31:0] mie_o,
  output logic [31:0] dpc_o,
  output logic [31:0] dcsr_o
);

  logic [11:0] xp_addr;
  logic        unused_excp_addr_hi;
  assign xp_addr             = excp_waddr_i[11:0];
  assign unused_excp_addr_hi = ^excp_waddr_i[31:12];

  function automatic logic hit(input logic [11:0] a);
    return (ex_we_i && ex_waddr_i == a) || (excp_we_i && xp_addr == a);
  endfunction

  // On a same-address collision the exception port's data is selected.
  function automatic logic [31:0] wsel(input logic [11:0] a);
    return (excp_we_i && xp_addr == a) ? excp_wdata_i : ex_wdata_i;
  endfunction

  logic        mst_mie, mst_mpie, dcsr_ebreakm;
  logic [31:0] mie_q, mtvec_q, mscratch_q, mepc_q, mcause_q;
  logic [31:0] dpc_q, dscratch0_q, dscratch1_q;
  logic [31:0] mstatus_wd, dcsr_wd;
  logic        trap_entry;
  logic [63:0] mcycle, minstret;

  assign mstatus_wd = wsel(CSR_MSTATUS);
  assign dcsr_wd    = wsel(CSR_DCSR);
  assign trap_entry = excp_we_i && (xp_addr == CSR_MCAUSE);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mst_mie      <= 1'b0;
      mst_mpie     <= 1'b0;
      dcsr_ebreakm <= 1'b0;
      mie_q        <= '0;
      mtvec_q      <= MTVEC_RST;
      mscratch_q   <= '0;
      mepc_q       <= '0;
      mcause_q     <= '0;
      dpc_q        <= '0;
      dscratch0_q  <= '0;
      dscratch1_q  <= '0;
    end else begin
      // Trap stacking outranks mret, which outranks a direct mstatus write.
      if (trap_entry) begin
        mst_mpie <= mst_mie;
        mst_mie  <= 1'b0;
      end else if (inst_mret_i) begin
        mst_mie  <= mst_mpie;
        mst_mpie <= 1'b1;
      end else if (hit(CSR_MSTATUS)) begin
        mst_mie  <= mstatus_wd[MSTATUS_MIE];
        mst_mpie <= mstatus_wd[MSTATUS_MPIE];
      end
      if (hit(CSR_MIE))       mie_q        <= wsel(CSR_MIE) & MIE_MASK;
      if (hit(CSR_MTVEC))     mtvec_q      <= wsel(CSR_MTVEC);
      if (hit(CSR_MSCRATCH))  mscratch_q   <= wsel(CSR_MSCRATCH);
      if (hit(CSR_MEPC))      mepc_q       <= wsel(CSR_MEPC) & ~32'h3;
      if (hit(CSR_MCAUSE))    mcause_q     <= wsel(CSR_MCAUSE);
      if (hit(CSR_DCSR))      dcsr_ebreakm <= dcsr_wd[DCSR_EBREAKM];
      if (hit(CSR_DPC))       dpc_q        <= wsel(CSR_DPC) & ~32'h3;
      if (hit(CSR_DSCRATCH0)) dscratch0_q  <= wsel(CSR_DSCRATCH0);
      if (hit(CSR_DSCRATCH1)) dscratch1_q  <= wsel(CSR_DSCRATCH1);
    end
  end

  csr_counter64 u_mcycle (
    .clk   (clk),
    .rst   (rst),
    .inc   (1'b1),
    .we_lo (hit(CSR_MCYCLE)),
    .we_hi (hit(CSR_MCYCLEH)),
    .wdata ({wsel(CSR_MCYCLEH), wsel(CSR_MCYCLE)}),
    .value (mcycle)
  );

  csr_counter64 u_minstret (
    .clk   (clk),
    .rst   (rst),
    .inc   (inst_retire_i),
    .we_lo (hit(CSR_MINSTRET)),
    .we_hi (hit(CSR_MINSTRETH)),
    .wdata ({wsel(CSR_MINSTRETH), wsel(CSR_MINSTRET)}),
    .value (minstret)
  );

  assign mstatus_o = {19'b0, MSTATUS_MPP, 3'b0, mst_mpie, 3'b0, mst_mie, 3'b0};
  assign dcsr_o    = {DCSR_XDEBUGVER, 12'b0, dcsr_ebreakm, 13'b0, DCSR_PRV};
  assign mtvec_o   = mtvec_q;
  assign mepc_o    = mepc_q;
  assign mie_o     = mie_q;
  assign dpc_o     = dpc_q;

  // Reads see pre-write state; there is deliberately no write bypass.
  always_comb begin
    rdata_o = '0;
    case (raddr_i)
      CSR_MSTATUS:                 rdata_o = mstatus_o;
      CSR_MISA:                    rdata_o = MISA_VAL;
      CSR_MIE:                     rdata_o = mie_q;
      CSR_MTVEC:                   rdata_o = mtvec_q;
      CSR_MSCRATCH:                rdata_o = mscratch_q;
      CSR_MEPC:                    rdata_o = mepc_q;
      CSR_MCAUSE:                  rdata_o = mcause_q;
      CSR_MIP:                     rdata_o = {20'b0, irq_external_i, 3'b0, irq_timer_i,
                                              3'b0, irq_software_i, 3'b0};
      CSR_MCYCLE, CSR_CYCLE:       rdata_o = mcycle[31:0];
      CSR_MCYCLEH, CSR_CYCLEH:     rdata_o = mcycle[63:32];
      CSR_MINSTRET, CSR_INSTRET:   rdata_o = minstret[31:0];
      CSR_MINSTRETH, CSR_INSTRETH: rdata_o = minstret[63:32];
      CSR_MHARTID:                 rdata_o = HART_ID;
      CSR_DCSR:                    rdata_o = dcsr_o;
      CSR_DPC:                     rdata_o = dpc_q;
      CSR_DSCRATCH0:               rdata_o = dscratch0_q;
      CSR_DSCRATCH1:               rdata_o = dscratch1_q;
      default:                     rdata_o = '0;
    endcase
  end

endmodule

// File: tb/tb_csr_file.sv
// Directed and randomized checks of csr_file against an address-keyed
// behavioural model of the CSR rules.
module tb_csr_file;

  localparam logic [31:0] HART  = 32'h0000_0005;
  localparam logic [31:0] MTRST = 32'h8000_0000;

  logic        clk = 1'b0;
  logic        rst;
  logic        ex_we;
  logic [11:0] ex_waddr;
  logic [31:0] ex_wdata;
  logic [11:0] raddr;
  logic [31:0] rdata;
  logic        excp_we;
  logic [31:0] excp_waddr;
  logic [31:0] excp_wdata;
  logic        mret, retire;
  logic        irq_s, irq_t, irq_e;
  logic [31:0] mtvec_o, mepc_o, mstatus_o, mie_o, dpc_o, dcsr_o;

  int checks = 0;
  int errors = 0;

  csr_file #(.HART_ID(HART), .MTVEC_RST(MTRST)) dut (
    .clk(clk), .rst(rst),
    .ex_we_i(ex_we), .ex_waddr_i(ex_waddr), .ex_wdata_i(ex_wdata),
    .raddr_i(raddr), .rdata_o(rdata),
    .excp_we_i(excp_we), .excp_waddr_i(excp_waddr), .excp_wdata_i(excp_wdata),
    .inst_mret_i(mret), .inst_retire_i(retire),
    .irq_software_i(irq_s), .irq_timer_i(irq_t), .irq_external_i(irq_e),
    .mtvec_o(mtvec_o), .mepc_o(mepc_o), .mstatus_o(mstatus_o),
    .mie_o(mie_o), .dpc_o(dpc_o), .dcsr_o(dcsr_o)
  );

  always #5 clk = ~clk;

  // Model: each implemented read/write CSR holds its architecturally visible value.
  bit [31:0] st [int];
  bit [63:0] cyc, ins, ncyc, nins;
  bit        cw, iw;

  function automatic void m_reset();
    st.delete();
    st['h300] = 32'h0000_1800;
    st['h304] = 0; st['h305] = MTRST; st['h340] = 0; st['h341] = 0; st['h342] = 0;
    st['h7B0] = 32'h4000_0003; st['h7B1] = 0; st['h7B2] = 0; st['h7B3] = 0;
    cyc = 0; ins = 0;
  endfunction

  function automatic void m_write(input int a, input bit [31:0] d);
    case (a)
      'h300: st[a] = 32'h1800 | (d & 32'h88);
      'h304: st[a] = d & 32'h888;
      'h305, 'h340, 'h342, 'h7B2, 'h7B3: st[a] = d;
      'h341, 'h7B1: st[a] = d & ~32'h3;
      'h7B0: st[a] = 32'h4000_0003 | (d & 32'h8000);
      'hB00: begin ncyc[31:0]  = d; cw = 1; end
      'hB80: begin ncyc[63:32] = d; cw = 1; end
      'hB02: begin nins[31:0]  = d; iw = 1; end
      'hB82: begin nins[63:32] = d; iw = 1; end
      default: ;
    endcase
  endfunction

  function automatic bit [31:0] m_read(input int a);
    case (a)
      'h301: return 32'h4000_0100;
      'h344: return (irq_e ? 32'h800 : 0) | (irq_t ? 32'h80 : 0) | (irq_s ? 32'h8 : 0);
      'hB00, 'hC00: return cyc[31:0];
      'hB80, 'hC80: return cyc[63:32];
      'hB02, 'hC02: return ins[31:0];
      'hB82, 'hC82: return ins[63:32];
      'hF14: return HART;
      default: return st.exists(a) ? st[a] : 32'h0;
    endcase
  endfunction

  // Advance the model by one clock using the inputs currently driven.
  function automatic void m_step();
    bit [31:0] old_ms = st['h300];
    int xa = int'(excp_waddr[11:0]);
    int ea = int'(ex_waddr);
    ncyc = cyc; nins = ins; cw = 0; iw = 0;
    if (ex_we && !(excp_we && xa == ea)) m_write(ea, ex_wdata);
    if (excp_we) m_write(xa, excp_wdata);
    if (excp_we && xa == 'h342) st['h300] = 32'h1800 | (old_ms[3] ? 32'h80 : 32'h0);
    else if (mret)              st['h300] = 32'h1880 | (old_ms[7] ? 32'h8 : 32'h0);
    if (!cw) ncyc = cyc + 1;
    if (!iw && retire) nins = ins + 1;
    cyc = ncyc; ins = nins;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic check_outputs();
    chk("mtvec_o", mtvec_o, st['h305]);
    chk("mepc_o", mepc_o, st['h341]);
    chk("mstatus_o", mstatus_o, st['h300]);
    chk("mie_o", mie_o, st['h304]);
    chk("dpc_o", dpc_o, st['h7B1]);
    chk("dcsr_o", dcsr_o, st['h7B0]);
    chk($sformatf("rdata@%h", raddr), rdata, m_read(int'(raddr)));
  endtask

  task automatic tick();
    @(negedge clk);
    check_outputs();
    @(posedge clk);
    m_step();
    #1;
  endtask

  task automatic clr();
    ex_we = 0; excp_we = 0; mret = 0; retire = 0;
  endtask

  task automatic ex_wr(input logic [11:0] a, input logic [31:0] d);
    ex_we = 1; ex_waddr = a; ex_wdata = d;
  endtask

  task automatic xp_wr(input logic [31:0] a, input logic [31:0] d);
    excp_we = 1; excp_waddr = a; excp_wdata = d;
  endtask

  task automatic rd(input string tag, input logic [11:0] a, input logic [31:0] exp);
    raddr = a;
    #1;
    chk(tag, rdata, exp);
  endtask

  logic [11:0] alist [20] = '{12'h300, 12'h301, 12'h304, 12'h305, 12'h340, 12'h341,
                              12'h342, 12'h344, 12'hB00, 12'hB80, 12'hB02, 12'hB82,
                              12'hC00, 12'h7B0, 12'h7B1, 12'h7B2, 12'h7B3, 12'hF14,
                              12'h7C0, 12'hC82};

  initial begin
    int n;
    rst = 1; clr();
    ex_waddr = 0; ex_wdata = 0; excp_waddr = 0; excp_wdata = 0;
    raddr = 12'h300; irq_s = 0; irq_t = 0; irq_e = 0;
    m_reset();
    #1;
    chk("rst_mstatus", mstatus_o, 32'h1800);
    chk("rst_dcsr", dcsr_o, 32'h4000_0003);
    chk("rst_mtvec", mtvec_o, MTRST);
    @(posedge clk); #1; rst = 0;

    // Field masks and read-only/unimplemented addresses
    ex_wr(12'h304, 32'hFFFF_FFFF); tick(); clr();
    rd("mie_mask", 12'h304, 32'h888);
    ex_wr(12'h7B0, 32'hFFFF_FFFF); tick(); clr();
    chk("dcsr_mask", dcsr_o, 32'h4000_8003);
    ex_wr(12'h301, 32'h1234_5678); tick(); clr();
    rd("misa_ro", 12'h301, 32'h4000_0100);
    rd("unimpl_7c0", 12'h7C0, 32'h0);
    rd("mhartid", 12'hF14, HART);

    // Port collision and independent writes (upper excp address bits ignored)
    ex_wr(12'h340, 32'hAAAA); xp_wr(32'h0000_0340, 32'h5555); tick(); clr();
    rd("collide_mscratch", 12'h340, 32'h5555);
    ex_wr(12'h7B2, 32'h11); xp_wr(32'hABCD_E7B3, 32'h22); tick(); clr();
    rd("dual_dscratch0", 12'h7B2, 32'h11);
    rd("dual_dscratch1", 12'h7B3, 32'h22);

    // Trap stacking and mret
    ex_wr(12'h300, 32'h8); tick(); clr();
    chk("mstatus_set_mie", mstatus_o, 32'h1808);
    xp_wr(32'h342, 32'h8000_000B); tick(); clr();
    chk("trap_mstatus_n1", mstatus_o, 32'h1880);
    xp_wr(32'h341, 32'h1236); tick(); clr();
    chk("trap_mepc", mepc_o, 32'h1234);
    chk("trap_mstatus", mstatus_o, 32'h1880);
    mret = 1; tick(); clr();
    chk("mret_mstatus", mstatus_o, 32'h1888);
    ex_wr(12'h300, 32'h0); xp_wr(32'h342, 32'h3); mret = 1; tick(); clr();
    chk("trap_over_mret_ex", mstatus_o, 32'h1880);
    ex_wr(12'h300, 32'h0); mret = 1; tick(); clr();
    chk("mret_over_ex", mstatus_o, 32'h1888);

    // mip is combinational; mtvec updates only after the edge
    irq_t = 1; rd("mip_timer", 12'h344, 32'h80);
    irq_t = 0; rd("mip_clear", 12'h344, 32'h0);
    ex_wr(12'h305, 32'h100); #1;
    chk("mtvec_same_cycle", mtvec_o, MTRST);
    tick(); clr();
    chk("mtvec_next_cycle", mtvec_o, 32'h100);

    // Counter wrap, write suppression, retire counting
    ex_wr(12'hB80, 32'hFFFF_FFFF); tick();
    ex_wr(12'hB00, 32'hFFFF_FFFE); tick(); clr();
    rd("mcycle_lo_pre", 12'hB00, 32'hFFFF_FFFE);
    rd("mcycle_hi_pre", 12'hB80, 32'hFFFF_FFFF);
    tick(); tick();
    rd("wrap_lo", 12'hB00, 32'h0);
    rd("wrap_hi", 12'hC80, 32'h0);
    tick();
    ex_wr(12'hB00, 32'h100); tick(); clr();
    rd("mcycle_write_noinc", 12'hB00, 32'h100);
    tick();
    rd("mcycle_after_write", 12'hC00, 32'h101);
    ex_wr(12'hB02, 32'h0); xp_wr(32'hB82, 32'h0); retire = 1; tick(); clr();
    n = 0;
    for (int i = 0; i < 40; i++) begin
      retire = 1'($urandom_range(0, 1));
      if (retire) n++;
      tick();
    end
    clr();
    rd("minstret_count", 12'hB02, 32'(n));
    rd("minstreth_zero", 12'hB82, 32'h0);

    // Randomized traffic on both ports
    for (int i = 0; i < 400; i++) begin
      ex_we      = ($urandom_range(0, 2) == 0);
      ex_waddr   = alist[$urandom_range(0, 19)];
      ex_wdata   = $urandom;
      excp_we    = ($urandom_range(0, 3) == 0);
      excp_waddr = {$urandom_range(0, 15) == 0 ? 20'h5A5A5 : 20'h0, alist[$urandom_range(0, 19)]};
      excp_wdata = $urandom;
      mret       = ($urandom_range(0, 7) == 0);
      retire     = 1'($urandom_range(0, 1));
      irq_s      = 1'($urandom_range(0, 1));
      irq_t      = 1'($urandom_range(0, 1));
      irq_e      = 1'($urandom_range(0, 1));
      raddr      = alist[$urandom_range(0, 19)];
      tick();
    end
    clr(); irq_s = 0; irq_t = 0; irq_e = 0;

    // Asynchronous mid-run reset
    ex_wr(12'h340, 32'hDEAD); tick(); clr();
    rst = 1; raddr = 12'hB00;
    #1;
    m_reset();
    chk("midrst_mstatus", mstatus_o, 32'h1800);
    chk("midrst_dcsr", dcsr_o, 32'h4000_0003);
    chk("midrst_mtvec", mtvec_o, MTRST);
    chk("midrst_mcycle", rdata, 32'h0);
    rd("midrst_mscratch", 12'h340, 32'h0);
    @(posedge clk); #1; rst = 0;
    rd("post_rst_mcycle", 12'hB00, 32'h0);
    for (int i = 0; i < 5; i++) tick();
    rd("post_rst_mcycle5", 12'hB00, 32'd5);
    tick();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
